// File: rtl/xy2_tx.sv
// rtl/xy2_tx.sv - XY2-100 transmitter: 20-bit SYNC/X/Y frames fed from a one-deep setpoint buffer
// Optional macro XY2_TX_STATUS_EN adds input xy_status and sticky output status_err.
module xy2_tx #(
  parameter int CLK_DIV = 5
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  input  logic        enable,
  input  logic        sp_valid,
  output logic        sp_ready,
  input  logic [15:0] sp_x,
  input  logic [15:0] sp_y,
  output logic        xy_clk,
  output logic        xy_sync,
  output logic        xy_x,
  output logic        xy_y,
  output logic        frame_done
`ifdef XY2_TX_STATUS_EN
  ,
  input  logic        xy_status,
  output logic        status_err
`endif
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_MID  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_PRE  = PW'(2 * CLK_DIV - 2);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [4:0]      bit_q, bit_d;
  logic [18:0]     sx_q, sx_d, sy_q, sy_d;
  logic [15:0]     act_x_q, act_x_d, act_y_q, act_y_d;
  logic [15:0]     pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic            pend_full_q, pend_full_d;
  logic            clk_q, clk_d, sync_q, sync_d, x_q, x_d, y_q, y_d, fd_q, fd_d;
  logic            load;
  logic [15:0]     next_x, next_y;
  logic [19:0]     fx, fy;

  function automatic logic [19:0] mk_frame(input logic [15:0] d);
    return {3'b001, d, ^{3'b001, d}};
  endfunction

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      act_x_q     <= 16'h8000;
      act_y_q     <= 16'h8000;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_full_q <= 1'b0;
      clk_q       <= 1'b0;
      sync_q      <= 1'b0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_full_q <= pend_full_d;
      clk_q       <= clk_d;
      sync_q      <= sync_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_full_d = pend_full_q;
    clk_d       = clk_q;
    sync_d      = sync_q;
    x_d         = x_q;
    y_d         = y_q;
    fd_d        = 1'b0;
    load        = 1'b0;
    next_x      = act_x_q;
    next_y      = act_y_q;
    fx          = '0;
    fy          = '0;

    case (state_q)
      IDLE: if (enable) load = 1'b1;
      SHIFT: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_MID) clk_d = 1'b0;
        // Registered pulse lands in the final cycle of bit 19
        if (phase_q == PH_PRE && bit_q == 5'd19) fd_d = 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == 5'd19) begin
            if (enable) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              bit_d   = '0;
              clk_d   = 1'b0;
              sync_d  = 1'b0;
              x_d     = 1'b0;
              y_d     = 1'b0;
            end
          end else begin
            bit_d  = bit_q + 5'd1;
            clk_d  = 1'b1;
            sync_d = (bit_q != 5'd18);
            x_d    = sx_q[18];
            y_d    = sy_q[18];
            sx_d   = {sx_q[17:0], 1'b0};
            sy_d   = {sy_q[17:0], 1'b0};
          end
        end
      end
    endcase

    if (load) begin
      if (pend_full_q) begin
        next_x = pend_x_q;
        next_y = pend_y_q;
      end
      fx          = mk_frame(next_x);
      fy          = mk_frame(next_y);
      act_x_d     = next_x;
      act_y_d     = next_y;
      sx_d        = fx[18:0];
      sy_d        = fy[18:0];
      x_d         = fx[19];
      y_d         = fy[19];
      clk_d       = 1'b1;
      sync_d      = 1'b1;
      phase_d     = '0;
      bit_d       = '0;
      state_d     = SHIFT;
      pend_full_d = 1'b0;
    end

    // An offer in the load cycle lands in pending and waits for the following frame
    if (sp_valid && !pend_full_q) begin
      pend_full_d = 1'b1;
      pend_x_d    = sp_x;
      pend_y_d    = sp_y;
    end
  end

  assign sp_ready   = ~pend_full_q;
  assign xy_clk     = clk_q;
  assign xy_sync    = sync_q;
  assign xy_x       = x_q;
  assign xy_y       = y_q;
  assign frame_done = fd_q;

`ifdef XY2_TX_STATUS_EN
  logic st_meta_q, st_sync_q, status_err_q;

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      st_meta_q    <= 1'b0;
      st_sync_q    <= 1'b0;
      status_err_q <= 1'b0;
    end else begin
      st_meta_q <= xy_status;
      st_sync_q <= st_meta_q;
      if (fd_q && st_sync_q) status_err_q <= 1'b1;
    end
  end

  assign status_err = status_err_q;
`endif

endmodule

// File: tb/tb_xy2_tx.sv
// tb/tb_xy2_tx.sv - scoreboard bench for xy2_tx: receiver model decodes frames, directed steps check them
// Define XY2_TX_STATUS_EN for both files to exercise the status path.
module tb_xy2_tx;

  logic        clk_ref = 1'b0;
  logic        sys_rstn;
  logic        enable;
  logic        sp_valid;
  logic        sp_ready;
  logic [15:0] sp_x, sp_y;
  logic        xy_clk, xy_sync, xy_x, xy_y, frame_done;
`ifdef XY2_TX_STATUS_EN
  logic        xy_status;
  logic        status_err;
`endif

  xy2_tx #(.CLK_DIV(5)) dut (
    .clk_ref    (clk_ref),
    .sys_rstn   (sys_rstn),
    .enable     (enable),
    .sp_valid   (sp_valid),
    .sp_ready   (sp_ready),
    .sp_x       (sp_x),
    .sp_y       (sp_y),
    .xy_clk     (xy_clk),
    .xy_sync    (xy_sync),
    .xy_x       (xy_x),
    .xy_y       (xy_y),
    .frame_done (frame_done)
`ifdef XY2_TX_STATUS_EN
    ,
    .xy_status  (xy_status),
    .status_err (status_err)
`endif
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct packed {
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] s;
    logic [7:0]  n;
  } rec_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  rec_t rx_q[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fd_prev = 0;
  int   fd_last = 0;
  int   bcnt = 0;
  logic prev_clk = 1'b0;
  logic [19:0] rx_x, rx_y, rx_s;

  // Reference receiver: samples on falling xy_clk, closes a frame on the low-sync bit
  always @(negedge clk_ref) begin
    cyc++;
    if (!sys_rstn) begin
      bcnt     = 0;
      prev_clk = 1'b0;
    end else begin
      if (prev_clk && !xy_clk) begin
        rx_x = {rx_x[18:0], xy_x};
        rx_y = {rx_y[18:0], xy_y};
        rx_s = {rx_s[18:0], xy_sync};
        bcnt++;
        if (!xy_sync) begin
          rx_q.push_back({rx_x, rx_y, rx_s, 8'(bcnt)});
          bcnt = 0;
        end
      end
      prev_clk = xy_clk;
      if (frame_done) begin
        fd_prev = fd_last;
        fd_last = cyc;
      end
    end
  end

  function automatic logic [19:0] ref_frame(input logic [15:0] d);
    logic [18:0] head;
    head = {3'b001, d};
    return {head, ^head};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] ex, input logic [15:0] ey);
    exp_q.push_back({ex, ey});
  endtask

  task automatic check_next(input string tag, output rec_t r);
    int   t;
    exp_t e;
    t = 0;
    r = '0;
    while (rx_q.size() == 0 && t < 1000) begin
      @(negedge clk_ref);
      t++;
    end
    chk({tag, "_avail"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0 && exp_q.size() != 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_x"},    32'(r.x), 32'(ref_frame(e.x)));
      chk({tag, "_y"},    32'(r.y), 32'(ref_frame(e.y)));
      chk({tag, "_sync"}, 32'(r.s), 32'h000F_FFFE);
      chk({tag, "_bits"}, 32'(r.n), 32'd20);
    end
  endtask

  task automatic sync_frame(input string tag);
    int   t;
    logic seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 1000) begin
      @(negedge clk_ref);
      seen = frame_done;
      t++;
    end
    #1;
    chk({tag, "_fd"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rec_t r;
    int   busy;
    sys_rstn = 1'b0;
    enable   = 1'b0;
    sp_valid = 1'b0;
    sp_x     = '0;
    sp_y     = '0;
`ifdef XY2_TX_STATUS_EN
    xy_status = 1'b0;
`endif
    repeat (4) @(negedge clk_ref);
    chk("rst_clk",   32'(xy_clk),     32'd0);
    chk("rst_sync",  32'(xy_sync),    32'd0);
    chk("rst_x",     32'(xy_x),       32'd0);
    chk("rst_y",     32'(xy_y),       32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    chk("rst_ready", 32'(sp_ready),   32'd1);

    // Release with enable high and no setpoint: default 8000 frames
    sys_rstn = 1'b1;
    enable   = 1'b1;
    expect_frame(16'h8000, 16'h8000);
    expect_frame(16'h8000, 16'h8000);
    @(negedge clk_ref);
    chk("lat_clk",  32'(xy_clk),  32'd1);
    chk("lat_sync", 32'(xy_sync), 32'd1);
    chk("lat_x",    32'(xy_x),    32'd0);
    chk("lat_y",    32'(xy_y),    32'd0);
    check_next("f1", r);
    chk("f1_const", 32'(r.x), 32'h0003_0000);
    check_next("f2", r);
    sync_frame("f2");
    chk("period", 32'(fd_last - fd_prev), 32'd200);

    // First pair accepted in b0 of f3, second stalls until the f4 load
    @(negedge clk_ref);
    sp_valid = 1'b1;
    sp_x     = 16'h1234;
    sp_y     = 16'hFFFF;
    expect_frame(16'h8000, 16'h8000);
    expect_frame(16'h1234, 16'hFFFF);
    @(negedge clk_ref);
    chk("hs_full", 32'(sp_ready), 32'd0);
    sp_x = 16'h0001;
    sp_y = 16'h00F0;
    repeat (20) @(negedge clk_ref);
    chk("hs_stall", 32'(sp_ready), 32'd0);
    sync_frame("f3");
    chk("hs_stall_end", 32'(sp_ready), 32'd0);
    @(negedge clk_ref);
    chk("hs_freed", 32'(sp_ready), 32'd1);
    @(negedge clk_ref);
    chk("hs_full2", 32'(sp_ready), 32'd0);
    sp_valid = 1'b0;
    expect_frame(16'h0001, 16'h00F0);
    expect_frame(16'h0001, 16'h00F0);
    check_next("f3", r);
    check_next("f4", r);
    chk("f4_rx_x", 32'(r.x[19:1]), 32'h0001_1234);
    chk("f4_rx_y", 32'(r.y[19:1]), 32'h0001_FFFF);
    chk("f4_par_x", 32'(^r.x), 32'd0);
    chk("f4_par_y", 32'(^r.y), 32'd0);
    check_next("f5", r);
    check_next("f6", r);
    sync_frame("f6");

    // Drop enable at b5 of f7: the frame still completes, then the bus idles
    repeat (51) @(negedge clk_ref);
    enable = 1'b0;
    expect_frame(16'h0001, 16'h00F0);
    check_next("f7", r);
    sync_frame("f7");
    busy = 0;
    repeat (30) begin
      @(negedge clk_ref);
      if (xy_clk || xy_sync || xy_x || xy_y) busy++;
    end
    chk("idle_quiet", 32'(busy), 32'd0);

    // Reset at b10: outputs drop asynchronously, setpoint returns to 8000
    enable = 1'b1;
    repeat (101) @(negedge clk_ref);
    chk("b10_clk", 32'(xy_clk), 32'd1);
    sys_rstn = 1'b0;
    #1;
    chk("arst_out", 32'({xy_clk, xy_sync, xy_x, xy_y, frame_done}), 32'd0);
    chk("arst_ready", 32'(sp_ready), 32'd1);
    @(negedge clk_ref);
    sys_rstn = 1'b1;
    expect_frame(16'h8000, 16'h8000);
    check_next("f9", r);

`ifdef XY2_TX_STATUS_EN
    sync_frame("st0");
    chk("st_clear", 32'(status_err), 32'd0);
    xy_status = 1'b1;
    sync_frame("st1");
    xy_status = 1'b0;
    @(negedge clk_ref);
    chk("st_set", 32'(status_err), 32'd1);
    sync_frame("st2");
    @(negedge clk_ref);
    chk("st_sticky", 32'(status_err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
